// File: rtl/m_mem_ctrl.sv
// rtl/m_mem_ctrl.sv - MEM-stage memory controller with req/ack data-memory handshake
//
// Decodes the M-stage load/store, places store data on byte lanes, runs a
// registered req/ack handshake to a variable-latency data memory, extends
// load data, stalls the pipeline while an access is outstanding and raises a
// one-cycle bus error if the memory never answers.
//
// Optional feature macro: M_MEM_CTRL_ALIGN_EXC_EN
//   defined   - misaligned lh/lhu/sh/lw/sw raise M_exc_adel / M_exc_ades and
//               issue no request
//   undefined - exception outputs tied 0, low address bits forced to the
//               natural alignment of the access
//
// Ports:
//   clk, reset (sync, active low)
//   M_op, M_fuc, M_valid, M_addr, M_wdata   M-stage instruction and operands
//   dm_req, dm_we, dm_be, dm_addr, dm_wdata registered memory request
//   dm_ack, dm_rdata                        memory completion and read word
//   M_rdata                                 extended load result
//   M_stall, M_bus_err                      pipeline freeze, timeout pulse
//   M_Tnew, M_for_mux_op                    hazard-unit information
//   M_exc_adel, M_exc_ades                  alignment exceptions

module m_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        M_op,
    input  logic [5:0]        M_fuc,
    input  logic              M_valid,
    input  logic [ADDR_W-1:0] M_addr,
    input  logic [31:0]       M_wdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic [31:0]       M_rdata,
    output logic              M_stall,
    output logic              M_bus_err,
    output logic [1:0]        M_Tnew,
    output logic [2:0]        M_for_mux_op,
    output logic              M_exc_adel,
    output logic              M_exc_ades
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, next_state;

    // funct field is not needed for memory decode
    logic unused_fuc;
    assign unused_fuc = ^M_fuc;

    logic is_load, is_store, is_byte, is_half, is_word, is_signed;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (M_op)
            OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign M_Tnew       = is_load ? 2'b01 : 2'b00;
    assign M_for_mux_op = {1'b0, (M_op == OP_JAL), is_load};

    logic       misaligned;
    logic [1:0] a_lo;

`ifdef M_MEM_CTRL_ALIGN_EXC_EN
    assign misaligned = (is_half & M_addr[0]) | (is_word & (M_addr[1:0] != 2'b00));
    assign a_lo       = M_addr[1:0];
    assign M_exc_adel = M_valid & is_load  & misaligned;
    assign M_exc_ades = M_valid & is_store & misaligned;
`else
    // Misaligned accesses are silently rounded down to natural alignment.
    assign misaligned = 1'b0;
    assign a_lo       = is_word ? 2'b00 : (is_half ? {M_addr[1], 1'b0} : M_addr[1:0]);
    assign M_exc_adel = 1'b0;
    assign M_exc_ades = 1'b0;
`endif

    logic mem_op;
    assign mem_op = M_valid & (is_load | is_store) & ~misaligned;

    // Store lane placement; loads drive no byte enables.
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    always_comb begin
        be_next    = 4'b0000;
        wdata_next = M_wdata;
        if (is_byte) begin
            wdata_next = {4{M_wdata[7:0]}};
            be_next    = 4'b0001 << a_lo;
        end else if (is_half) begin
            wdata_next = {2{M_wdata[15:0]}};
            be_next    = a_lo[1] ? 4'b1100 : 4'b0011;
        end else if (is_word) begin
            be_next    = 4'b1111;
        end
        if (!is_store) begin
            be_next = 4'b0000;
        end
    end

    // Load shape captured at issue, used when the ack returns.
    logic       ld_byte, ld_half, ld_signed;
    logic [1:0] a_q;
    logic [7:0] cnt;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;

    always_comb begin
        case (a_q)
            2'd0:    byte_sel = dm_rdata[7:0];
            2'd1:    byte_sel = dm_rdata[15:8];
            2'd2:    byte_sel = dm_rdata[23:16];
            default: byte_sel = dm_rdata[31:24];
        endcase
        half_sel = a_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        if (ld_byte) begin
            ld_extend_byte: ld_ext = {{24{ld_signed & byte_sel[7]}}, byte_sel};
        end else if (ld_half) begin
            ld_ext = {{16{ld_signed & half_sel[15]}}, half_sel};
        end else begin
            ld_ext = dm_rdata;
        end
    end

    logic timeout_hit;
    assign timeout_hit = (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        M_stall    = 1'b0;
        case (state)
            S_IDLE: begin
                M_stall = mem_op;
                if (mem_op) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                M_stall = 1'b1;
                if (dm_ack || timeout_hit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= 4'b0000;
            dm_addr   <= '0;
            dm_wdata  <= 32'h0;
            M_rdata   <= 32'h0;
            M_bus_err <= 1'b0;
            cnt       <= 8'h0;
            ld_byte   <= 1'b0;
            ld_half   <= 1'b0;
            ld_signed <= 1'b0;
            a_q       <= 2'b00;
        end else begin
            M_bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        dm_req    <= 1'b1;
                        dm_we     <= is_store;
                        dm_be     <= be_next;
                        dm_addr   <= {M_addr[ADDR_W-1:2], 2'b00};
                        dm_wdata  <= wdata_next;
                        ld_byte   <= is_byte;
                        ld_half   <= is_half;
                        ld_signed <= is_signed;
                        a_q       <= a_lo;
                        cnt       <= 8'h0;
                    end
                end
                S_WAIT: begin
                    // ack has priority over a timeout in the same cycle
                    if (dm_ack) begin
                        M_rdata <= ld_ext;
                        dm_req  <= 1'b0;
                        cnt     <= 8'h0;
                    end else if (timeout_hit) begin
                        dm_req    <= 1'b0;
                        M_bus_err <= 1'b1;
                        M_rdata   <= 32'h0;
                        cnt       <= 8'h0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// tb/tb_m_mem_ctrl.sv - self-checking bench for m_mem_ctrl with a behavioural model

module tb_m_mem_ctrl;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] JAL = 6'b000011;

    logic              clk;
    logic              reset;
    logic [5:0]        M_op;
    logic [5:0]        M_fuc;
    logic              M_valid;
    logic [ADDR_W-1:0] M_addr;
    logic [31:0]       M_wdata;
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic [31:0]       dm_rdata;
    logic [31:0]       M_rdata;
    logic              M_stall;
    logic              M_bus_err;
    logic [1:0]        M_Tnew;
    logic [2:0]        M_for_mux_op;
    logic              M_exc_adel;
    logic              M_exc_ades;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] model_rdata = 32'h0;

    m_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .M_op(M_op), .M_fuc(M_fuc), .M_valid(M_valid),
        .M_addr(M_addr), .M_wdata(M_wdata), .dm_req(dm_req), .dm_we(dm_we),
        .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .M_rdata(M_rdata), .M_stall(M_stall),
        .M_bus_err(M_bus_err), .M_Tnew(M_Tnew), .M_for_mux_op(M_for_mux_op),
        .M_exc_adel(M_exc_adel), .M_exc_ades(M_exc_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit f_is_load(input logic [5:0] op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    endfunction

    function automatic bit f_is_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic int f_size(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit f_misaligned(input logic [5:0] op, input logic [31:0] a);
        int sz = f_size(op);
        return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] f_be(input logic [5:0] op, input logic [31:0] a);
        int sz = f_size(op);
        int off = int'(a % 4);
        if (sz == 1) return 4'(1 << off);
        if (sz == 2) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [5:0] op, input logic [31:0] w);
        int sz = f_size(op);
        if (sz == 1) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] f_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] r);
        int sz = f_size(op);
        int off;
        int bits;
        logic [31:0] v;
        bit sgn = (op == LB) || (op == LH);
        if (sz == 4) return r;
        off  = (sz == 1) ? int'(a % 4) : int'((a % 4) / 2) * 2;
        bits = 8 * sz;
        v = (r >> (8 * off)) & ((32'h1 << bits) - 32'h1);
        if (sgn && v >= (32'h1 << (bits - 1))) v = v - (32'h1 << bits);
        return v;
    endfunction

    // ---------------- scenarios ----------------
    task automatic do_access(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] w, input logic [31:0] r,
                             input int lat, input string tag);
        bit exc;
        bit acked;
`ifdef M_MEM_CTRL_ALIGN_EXC_EN
        exc = f_misaligned(op, addr);
`else
        exc = 1'b0;
`endif
        acked = (lat < TIMEOUT);
        @(negedge clk);
        M_op = op; M_addr = addr; M_wdata = w; M_valid = 1'b1; dm_ack = 1'b0;
        #1;
        total_cnt++; if (M_stall !== !exc) $display("FAIL %s issue_stall: got %b want %b", tag, M_stall, !exc); else pass_cnt++;
        total_cnt++; if (M_Tnew !== (f_is_load(op) ? 2'b01 : 2'b00)) $display("FAIL %s tnew: got %b", tag, M_Tnew); else pass_cnt++;
        total_cnt++; if (M_for_mux_op !== {2'b00, f_is_load(op)}) $display("FAIL %s fmux: got %b", tag, M_for_mux_op); else pass_cnt++;
        total_cnt++; if (M_exc_adel !== (exc & f_is_load(op))) $display("FAIL %s adel: got %b want %b", tag, M_exc_adel, exc & f_is_load(op)); else pass_cnt++;
        total_cnt++; if (M_exc_ades !== (exc & f_is_store(op))) $display("FAIL %s ades: got %b want %b", tag, M_exc_ades, exc & f_is_store(op)); else pass_cnt++;
        if (exc) begin
            @(negedge clk);
            total_cnt++; if (dm_req !== 1'b0) $display("FAIL %s exc_no_req: got %b want 0", tag, dm_req); else pass_cnt++;
            M_valid = 1'b0;
            return;
        end
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            total_cnt++; if (dm_req !== 1'b1) $display("FAIL %s wait_req k=%0d: got %b want 1", tag, k, dm_req); else pass_cnt++;
            total_cnt++; if (dm_addr !== (addr & ~32'h3)) $display("FAIL %s dm_addr: got %h want %h", tag, dm_addr, addr & ~32'h3); else pass_cnt++;
            if (k == 0) begin
                total_cnt++; if (dm_we !== f_is_store(op)) $display("FAIL %s dm_we: got %b want %b", tag, dm_we, f_is_store(op)); else pass_cnt++;
                if (f_is_store(op)) begin
                    total_cnt++; if (dm_be !== f_be(op, addr)) $display("FAIL %s dm_be: got %b want %b", tag, dm_be, f_be(op, addr)); else pass_cnt++;
                    total_cnt++; if (dm_wdata !== f_wdata(op, w)) $display("FAIL %s dm_wdata: got %h want %h", tag, dm_wdata, f_wdata(op, w)); else pass_cnt++;
                end
            end
            dm_ack   = (k == lat);
            dm_rdata = (k == lat) ? r : $urandom;
            #1;
            total_cnt++; if (M_stall !== 1'b1) $display("FAIL %s wait_stall k=%0d: got %b want 1", tag, k, M_stall); else pass_cnt++;
            if (k == lat) break;
        end
        @(negedge clk);
        dm_ack = 1'b0;
        #1;
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL %s done_req: got %b want 0", tag, dm_req); else pass_cnt++;
        total_cnt++; if (M_stall !== 1'b0) $display("FAIL %s done_stall: got %b want 0", tag, M_stall); else pass_cnt++;
        total_cnt++; if (M_bus_err !== !acked) $display("FAIL %s bus_err: got %b want %b", tag, M_bus_err, !acked); else pass_cnt++;
        if (f_is_load(op) || !acked) begin
            model_rdata = acked ? f_load(op, addr, r) : 32'h0;
            total_cnt++; if (M_rdata !== model_rdata) $display("FAIL %s rdata: got %h want %h", tag, M_rdata, model_rdata); else pass_cnt++;
        end
        M_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (M_bus_err !== 1'b0) $display("FAIL %s err_pulse: got %b want 0", tag, M_bus_err); else pass_cnt++;
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL %s idle_req: got %b want 0", tag, dm_req); else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0; M_valid = 1'b0; M_op = 6'h0; M_fuc = 6'h0; M_addr = 32'h0;
        M_wdata = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
        repeat (3) @(negedge clk);
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dm_req); else pass_cnt++;
        total_cnt++; if ({dm_we, dm_be} !== 5'b0) $display("FAIL reset_we_be: got %b want 0", {dm_we, dm_be}); else pass_cnt++;
        total_cnt++; if (dm_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", dm_addr); else pass_cnt++;
        total_cnt++; if (dm_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", dm_wdata); else pass_cnt++;
        total_cnt++; if (M_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", M_rdata); else pass_cnt++;
        total_cnt++; if ({M_stall, M_bus_err} !== 2'b00) $display("FAIL reset_stall_err: got %b want 00", {M_stall, M_bus_err}); else pass_cnt++;
        reset = 1'b1;
        model_rdata = 32'h0;
    endtask

    task automatic test_bubble();
        @(negedge clk);
        M_valid = 1'b0; M_op = LW; M_addr = $urandom;
        #1;
        total_cnt++; if (M_stall !== 1'b0) $display("FAIL bubble_stall: got %b want 0", M_stall); else pass_cnt++;
        total_cnt++; if (M_Tnew !== 2'b01) $display("FAIL bubble_tnew: got %b want 01", M_Tnew); else pass_cnt++;
        M_op = JAL;
        #1;
        total_cnt++; if (M_for_mux_op !== 3'b010) $display("FAIL jal_fmux: got %b want 010", M_for_mux_op); else pass_cnt++;
        total_cnt++; if (M_Tnew !== 2'b00) $display("FAIL jal_tnew: got %b want 00", M_Tnew); else pass_cnt++;
        M_valid = 1'b1; M_op = 6'b000000;
        #1;
        total_cnt++; if (M_stall !== 1'b0) $display("FAIL rtype_stall: got %b want 0", M_stall); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL bubble_req: got %b want 0", dm_req); else pass_cnt++;
        M_valid = 1'b0;
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        M_valid = 1'b0; dm_ack = 1'b1; dm_rdata = $urandom;
        repeat (3) @(negedge clk);
        total_cnt++; if (M_rdata !== model_rdata) $display("FAIL ack_idle_rdata: got %h want %h", M_rdata, model_rdata); else pass_cnt++;
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL ack_idle_req: got %b want 0", dm_req); else pass_cnt++;
        dm_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int err_cnt = 0;
        @(negedge clk);
        M_op = SH; M_addr = 32'h0000_0042; M_wdata = 32'h1234_5678; M_valid = 1'b1; dm_ack = 1'b0;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            @(negedge clk);
            if (dm_req === 1'b1) req_cnt++;
            if (M_bus_err === 1'b1) begin
                err_cnt++;
                M_valid = 1'b0;
            end
        end
        #1;
        total_cnt++; if (req_cnt != TIMEOUT) $display("FAIL timeout_req_cycles: got %0d want %0d", req_cnt, TIMEOUT); else pass_cnt++;
        total_cnt++; if (err_cnt != 1) $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt); else pass_cnt++;
        total_cnt++; if (M_stall !== 1'b0) $display("FAIL timeout_stall: got %b want 0", M_stall); else pass_cnt++;
        total_cnt++; if (M_rdata !== 32'h0) $display("FAIL timeout_rdata: got %h want 0", M_rdata); else pass_cnt++;
        model_rdata = 32'h0;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        M_op = LW; M_addr = 32'h0000_0080; M_valid = 1'b1; dm_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0; M_valid = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL rst_wait_req: got %b want 0", dm_req); else pass_cnt++;
        total_cnt++; if (M_stall !== 1'b0) $display("FAIL rst_wait_stall: got %b want 0", M_stall); else pass_cnt++;
        reset = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dm_ack = 1'b0;
        @(negedge clk);
        total_cnt++; if (M_rdata !== 32'h0) $display("FAIL late_ack_rdata: got %h want 0", M_rdata); else pass_cnt++;
        total_cnt++; if (dm_req !== 1'b0) $display("FAIL late_ack_req: got %b want 0", dm_req); else pass_cnt++;
        total_cnt++; if (M_stall !== 1'b0) $display("FAIL late_ack_stall: got %b want 0", M_stall); else pass_cnt++;
        model_rdata = 32'h0;
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        ops[0] = LB; ops[1] = LH; ops[2] = LW; ops[3] = LBU;
        ops[4] = LHU; ops[5] = SB; ops[6] = SH; ops[7] = SW;
        for (int i = 0; i < 40; i++) begin
            int lat = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 5));
            do_access(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, lat, "rand");
        end
    endtask

    initial begin
        test_reset();
        do_access(LW, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, "lw");
        test_ack_idle();
        do_access(SB, 32'h0000_0023, 32'h0000_00AB, $urandom, 0, "sb");
        do_access(LB, 32'h0000_0032, 32'h0, 32'h0080_FF00, 1, "lb");
        do_access(LBU, 32'h0000_0032, 32'h0, 32'h0080_FF00, 2, "lbu");
        test_timeout();
        do_access(LHU, 32'h0000_0046, 32'h0, 32'h8765_4321, TIMEOUT - 1, "ack_at_limit");
        test_reset_mid_wait();
        do_access(LW, 32'h0000_0102, 32'h0, 32'h1122_3344, 0, "misaligned_lw");
        test_bubble();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
